seq_counter_gen: RTL and testbench
==================================

# seq_counter_gen

Parametrised sequence counter with registered one-hot timing decode for the CPU control unit. It generalises the fixed 8-bit sequence counter:
- Counter width and number of timing states are parameters.
- Adds synchronous clear, parallel load, increment enable, and a selectable wrap or saturate mode.
- Adds terminal-count, wrap-pulse, load-error and sticky overflow status.

The control unit drives it to step instruction phases T0..T(NUM_T-1).

## Interface
- `WIDTH`, default 8: counter width in bits.
- `NUM_T`, default 16: number of timing states.
  - LAST = NUM_T-1 is the terminal count.
  - Legal range is 2 ≤ NUM_T ≤ 2^WIDTH.
- `clk` input, 1: clock, rising-edge active.
- `rst` input, 1: reset, asynchronous and active-high.
- `clr` input, 1: synchronous clear to 0.
- `ld` input, 1: synchronous parallel load of `ld_val`.
- `ld_val` input, WIDTH: load value.
- `inc` input, 1: increment enable.
- `sat` input, 1: mode select. 1 = saturate at LAST; 0 = wrap LAST→0.
- `data_out` output, WIDTH: current count, registered.
- `t_out` output, NUM_T: one-hot timing decode; bit k is high when `data_out`==k. Registered.
- `tc` output, 1: high while `data_out`==LAST. Registered.
- `wrap_p` output, 1: one-cycle pulse on a LAST→0 wrap.
- `ld_err` output, 1: one-cycle pulse when a load is rejected.
- `ovf` output, 1: sticky flag, set by increment-at-LAST in saturate mode.

## Operation
- **Reset** (asynchronous, takes effect immediately, held while `rst`=1):
  - `data_out`=0, `t_out`=1 (T0 only), `tc`=0.
  - `wrap_p`=0, `ld_err`=0, `ovf`=0.
- **Priority per clock edge:** `clr` > `ld` > `inc` > hold.
- **clr:** `data_out`←0, `ovf`←0. `ld` and `inc` are ignored that cycle.
- **ld, valid** (`ld_val` ≤ LAST): `data_out`←`ld_val`. `inc` is ignored.
- **ld, invalid** (`ld_val` > LAST): `data_out` holds and `ld_err` pulses for 1 cycle. `inc` is still ignored.
- **inc, `data_out`<LAST:** `data_out`←`data_out`+1.
- **inc, `data_out`==LAST, `sat`=0:** `data_out`←0 and `wrap_p` pulses for 1 cycle.
- **inc, `data_out`==LAST, `sat`=1:** `data_out` holds at LAST and `ovf`←1. `ovf` stays set until `clr` or `rst`.
- **No control asserted:** all state holds. `wrap_p` and `ld_err` return to 0.
- **Invariants:**
  - `data_out` ≤ LAST always.
  - `t_out` is exactly one-hot always and equals 1<<`data_out`.
  - `tc` = (`data_out`==LAST).
- **Width rule:** the increment is WIDTH-bit unsigned. The compare against LAST is done at WIDTH bits, so NUM_T = 2^WIDTH wraps naturally without a width-overflow artefact.
- **Mode change:** `sat` is sampled only on an increment at LAST, so switching mode mid-count has no other effect.

## Timing
- All outputs are registered and update on the same rising edge.
  - `t_out`, `tc`, `wrap_p` and `ld_err` are never combinational glitches relative to `data_out`.
  - They are computed from the next-state value.
- **Latency:** a control sampled at edge N is visible on the outputs after edge N.
- **`inc` held continuously:** the count advances 1 per cycle.
- **Reset mid-count:** outputs go to their reset values asynchronously, with no waiting for `clk`.
- **First edge after `rst` falls:** it acts on the inputs normally. `inc`=1 at that edge gives `data_out`=1.
- **Simultaneous `clr` and `ld` with an invalid `ld_val`:** `clr` wins and `ld_err` stays 0.
- **`wrap_p` and `ld_err`:** they are exactly one cycle wide per event. Back-to-back events give back-to-back pulses; a repeated event keeps the signal high.

## Test plan
- **Reset and count:** `rst` pulse, then `inc`=1 for 20 cycles (WIDTH=8, NUM_T=16, `sat`=0).
  - Required: `data_out` 0,1,…,15,0,1,2,3,4; `wrap_p` high only on the 15→0 cycle.
  - Required: `t_out` one-hot matching each count; `tc` high only at 15.
- **Saturate:** `sat`=1, `inc`=1 from 0 for 18 cycles.
  - Required: `data_out` sticks at 15, `ovf` rises on the first increment at 15 and stays 1, no `wrap_p`.
  - Then `clr`=1 for 1 cycle: `data_out`=0, `ovf`=0.
- **Load:** `ld`=1 with `ld_val`=9 → `data_out`=9 and `t_out`=0x0200. `ld`=1 with `ld_val`=20 → `data_out` stays 9 and `ld_err` pulses for 1 cycle.
- **Priority:** `clr`=`ld`=`inc`=1 with `ld_val`=5 → `data_out`=0. Then `ld`=`inc`=1 with `ld_val`=5 → `data_out`=5, not 6.
- **Async reset mid-count:** at `data_out`=7, assert `rst` between clock edges.
  - Required: `data_out`=0, `t_out`=1 and `ovf`=0 before the next `clk` edge.
  - Release `rst` with `inc`=1: the next edge gives 1.
- **Parameter sweep:**
  - WIDTH=4, NUM_T=16: full wrap 15→0 with no X and `t_out` always one-hot.
  - WIDTH=3, NUM_T=5: wrap 4→0.

Source files
------------

// File: rtl/seq_counter_gen.sv
// seq_counter_gen: parametrised instruction-phase sequence counter
// with registered one-hot timing decode and status flags.
module seq_counter_gen #(
    parameter int WIDTH = 8,
    parameter int NUM_T = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             ld,
    input  logic [WIDTH-1:0] ld_val,
    input  logic             inc,
    input  logic             sat,
    output logic [WIDTH-1:0] data_out,
    output logic [NUM_T-1:0] t_out,
    output logic             tc,
    output logic             wrap_p,
    output logic             ld_err,
    output logic             ovf
);

    // Terminal count held at WIDTH bits so NUM_T = 2^WIDTH fits exactly.
    localparam logic [WIDTH-1:0] LAST = WIDTH'(NUM_T - 1);
    localparam logic [NUM_T-1:0] T0   = NUM_T'(1);

    logic [WIDTH-1:0] r_cnt;
    logic [NUM_T-1:0] r_t;
    logic             r_tc;
    logic             r_wrap;
    logic             r_lerr;
    logic             r_ovf;

    logic [WIDTH-1:0] w_nxt;
    logic [NUM_T-1:0] w_t;
    logic             w_at_last;
    logic             w_ld_ok;
    logic             w_wrap;
    logic             w_lerr;
    logic             w_ovf;

    assign w_at_last = (r_cnt == LAST);
    assign w_ld_ok   = (ld_val <= LAST);

    // Next-state selection: clr > ld > inc > hold.
    always_comb begin
        w_nxt  = r_cnt;
        w_wrap = 1'b0;
        w_lerr = 1'b0;
        w_ovf  = r_ovf;
        if (clr) begin
            w_nxt = '0;
            w_ovf = 1'b0;
        end else if (ld) begin
            if (w_ld_ok) begin
                w_nxt = ld_val;
            end else begin
                w_lerr = 1'b1;
            end
        end else if (inc) begin
            if (!w_at_last) begin
                w_nxt = r_cnt + WIDTH'(1);
            end else if (sat) begin
                w_ovf = 1'b1;
            end else begin
                w_nxt  = '0;
                w_wrap = 1'b1;
            end
        end
    end

    // One-hot decode of the next count so the timing bits register
    // in the same edge as the count itself.
    always_comb begin
        w_t = '0;
        for (int k = 0; k < NUM_T; k++) begin
            w_t[k] = (w_nxt == WIDTH'(k));
        end
    end

    // State and status registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt  <= '0;
            r_t    <= T0;
            r_tc   <= 1'b0;
            r_wrap <= 1'b0;
            r_lerr <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_cnt  <= w_nxt;
            r_t    <= w_t;
            r_tc   <= (w_nxt == LAST);
            r_wrap <= w_wrap;
            r_lerr <= w_lerr;
            r_ovf  <= w_ovf;
        end
    end

    assign data_out = r_cnt;
    assign t_out    = r_t;
    assign tc       = r_tc;
    assign wrap_p   = r_wrap;
    assign ld_err   = r_lerr;
    assign ovf      = r_ovf;

endmodule

// File: tb/tb_seq_counter_gen.sv
// tb_seq_counter_gen: directed self-checking bench for seq_counter_gen
// at the default size plus two reduced parameter sets.
module tb_seq_counter_gen;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        ld;
    logic        inc;
    logic        sat;
    logic [7:0]  ld_val;
    logic [7:0]  d8;
    logic [15:0] t8;
    logic        tc8, wr8, le8, ov8;

    logic [3:0]  lv4;
    logic [3:0]  d4;
    logic [15:0] t4;
    logic        tc4, wr4, le4, ov4;

    logic [2:0]  lv3;
    logic [2:0]  d3;
    logic [4:0]  t3;
    logic        tc3, wr3, le3, ov3;

    int n_run  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    assign lv4 = ld_val[3:0];
    assign lv3 = ld_val[2:0];

    seq_counter_gen #(.WIDTH(8), .NUM_T(16)) u_dut (
        .clk(clk), .rst(rst), .clr(clr), .ld(ld), .ld_val(ld_val),
        .inc(inc), .sat(sat), .data_out(d8), .t_out(t8), .tc(tc8),
        .wrap_p(wr8), .ld_err(le8), .ovf(ov8)
    );

    seq_counter_gen #(.WIDTH(4), .NUM_T(16)) u_w4 (
        .clk(clk), .rst(rst), .clr(clr), .ld(ld), .ld_val(lv4),
        .inc(inc), .sat(sat), .data_out(d4), .t_out(t4), .tc(tc4),
        .wrap_p(wr4), .ld_err(le4), .ovf(ov4)
    );

    seq_counter_gen #(.WIDTH(3), .NUM_T(5)) u_w3 (
        .clk(clk), .rst(rst), .clr(clr), .ld(ld), .ld_val(lv3),
        .inc(inc), .sat(sat), .data_out(d3), .t_out(t3), .tc(tc3),
        .wrap_p(wr3), .ld_err(le3), .ovf(ov3)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_run++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk8(input string tag, input int c, input logic w,
                        input logic e, input logic o);
        chk({tag, ".cnt"}, 32'(d8), 32'(c));
        chk({tag, ".t"}, 32'(t8), 32'(1) << c);
        chk({tag, ".tc"}, 32'(tc8), 32'(c == 15));
        chk({tag, ".wrap"}, 32'(wr8), 32'(w));
        chk({tag, ".lerr"}, 32'(le8), 32'(e));
        chk({tag, ".ovf"}, 32'(ov8), 32'(o));
    endtask

    initial begin
        rst = 1'b1; clr = 1'b0; ld = 1'b0; inc = 1'b0; sat = 1'b0;
        ld_val = '0;
        #12;
        chk8("reset", 0, 1'b0, 1'b0, 1'b0);

        // Reset and count with wrap
        @(negedge clk);
        rst = 1'b0;
        inc = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            chk8($sformatf("cnt%0d", i), i % 16, (i % 16) == 0,
                 1'b0, 1'b0);
        end

        // Saturate
        inc = 1'b0; clr = 1'b1;
        step();
        chk8("clr0", 0, 1'b0, 1'b0, 1'b0);
        clr = 1'b0; sat = 1'b1; inc = 1'b1;
        for (int i = 1; i <= 18; i++) begin
            step();
            chk8($sformatf("sat%0d", i), (i > 15) ? 15 : i, 1'b0,
                 1'b0, i > 15);
        end
        inc = 1'b0; clr = 1'b1;
        step();
        chk8("satclr", 0, 1'b0, 1'b0, 1'b0);
        clr = 1'b0;

        // Load
        ld = 1'b1; ld_val = 8'd9; inc = 1'b1;
        step();
        chk8("ld9", 9, 1'b0, 1'b0, 1'b0);
        chk("ld9.t_hex", 32'(t8), 32'h0200);
        ld_val = 8'd20;
        step();
        chk8("ld20", 9, 1'b0, 1'b1, 1'b0);
        step();
        chk8("ld20b", 9, 1'b0, 1'b1, 1'b0);
        ld = 1'b0; inc = 1'b0;
        step();
        chk8("ldidle", 9, 1'b0, 1'b0, 1'b0);

        // Priority
        clr = 1'b1; ld = 1'b1; inc = 1'b1; ld_val = 8'd5;
        step();
        chk8("pri_clr", 0, 1'b0, 1'b0, 1'b0);
        clr = 1'b0;
        step();
        chk8("pri_ld", 5, 1'b0, 1'b0, 1'b0);
        clr = 1'b1; ld_val = 8'd200; inc = 1'b0;
        step();
        chk8("pri_clrbad", 0, 1'b0, 1'b0, 1'b0);

        // Async reset mid-count, with ovf set beforehand
        clr = 1'b0; ld = 1'b1; ld_val = 8'd15;
        step();
        ld = 1'b0; inc = 1'b1; sat = 1'b1;
        step();
        chk8("preovf", 15, 1'b0, 1'b0, 1'b1);
        inc = 1'b0; ld = 1'b1; ld_val = 8'd7;
        step();
        chk8("ld7", 7, 1'b0, 1'b0, 1'b1);
        ld = 1'b0;
        #3;
        rst = 1'b1;
        #1;
        chk8("arst", 0, 1'b0, 1'b0, 1'b0);
        inc = 1'b1; sat = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step();
        chk8("arst_inc", 1, 1'b0, 1'b0, 1'b0);

        // Parameter sweep on reduced instances
        inc = 1'b0; clr = 1'b1;
        step();
        chk("w4.clr", 32'(d4), 32'd0);
        chk("w3.clr", 32'(d3), 32'd0);
        clr = 1'b0; inc = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step();
            chk($sformatf("w4.cnt%0d", i), 32'(d4), 32'(i % 16));
            chk($sformatf("w4.t%0d", i), 32'(t4), 32'(1) << (i % 16));
            chk($sformatf("w4.x%0d", i), 32'($isunknown({d4, t4})), 32'd0);
            chk($sformatf("w4.wr%0d", i), 32'(wr4), 32'((i % 16) == 0));
            chk($sformatf("w3.cnt%0d", i), 32'(d3), 32'(i % 5));
            chk($sformatf("w3.t%0d", i), 32'(t3), 32'(1) << (i % 5));
            chk($sformatf("w3.tc%0d", i), 32'(tc3), 32'((i % 5) == 4));
            chk($sformatf("w3.wr%0d", i), 32'(wr3), 32'((i % 5) == 0));
        end
        inc = 1'b0; ld = 1'b1; ld_val = 8'd6;
        step();
        chk("w3.ldbad.cnt", 32'(d3), 32'(20 % 5));
        chk("w3.ldbad.err", 32'(le3), 32'd1);
        chk("w4.ld6", 32'(d4), 32'd6);
        ld = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
